handshake_sender: RTL and testbench
===================================

Name: handshake_sender

Overview:
- Four-phase req/ack initiator that carries a WIDTH-bit word out of the Clock domain to an asynchronous responder (external board logic or another clock domain).
- It is the outbound counterpart of the two-flop input synchronizer: the single async input ack_in passes through an internal 2-FF synchronizer; req_out and data_out are driven straight from flops.
- A one-entry pending slot absorbs one send that arrives during a transfer.

Parameters:
- WIDTH, 8, width of data_in/data_out.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- send  input  1  one-cycle request to transfer data_in; synchronous to Clock.
- data_in  input  WIDTH  word sampled in the cycle send=1.
- ack_in  input  1  asynchronous acknowledge from responder; synchronized internally.
- req_out  output  1  registered four-phase request.
- data_out  output  WIDTH  registered word; stable whenever req_out=1 and until ack_s falls.
- busy  output  1  1 whenever state != IDLE.
- full  output  1  pending slot occupied.
- done  output  1  one-cycle pulse when a transfer completes (ack_s seen low in RETURN).
- overflow  output  1  one-cycle pulse when a send is dropped.

Behaviour:
- Interface clocking: one clock. Reset is synchronous and active-high, named Reset; clock port named Clock.
- Reset: all outputs 0; state=IDLE; pending cleared; both synchronizer flops 0. Reset has priority over every other event, including mid-transfer (req_out drops on the next edge).
- ack_s = ack_in after two Clock flops (2-cycle latency). The FSM uses only ack_s, never ack_in.
- States:
  - IDLE: if send=1 and ack_s=0, latch data_in into data_out and set req_out=1 at the next edge (1-cycle latency); go to REQ.
  - IDLE with ack_s=1: the responder has not returned to zero. A send is stored in pending and no request is raised. When ack_s falls, pending launches: data_out/req_out are set at the next edge and the FSM goes to REQ.
  - REQ: hold req_out=1 and data_out. When ack_s=1, clear req_out at the next edge and go to RETURN.
  - RETURN: req_out=0, data_out held. When ack_s=0, pulse done for one cycle, then:
    - if pending is valid, load pending into data_out, set req_out=1 at the next edge, clear pending, go to REQ (back-to-back, no IDLE cycle);
    - else, if send=1 this cycle, launch data_in the same way;
    - else go to IDLE.
- Pending slot:
  - A send while busy with pending empty stores data_in and sets full.
  - A send while busy with pending full is dropped, pulses overflow, and leaves pending unchanged.
- Completion cycle (RETURN with ack_s=0) with send=1:
  - pending full: pending launches and data_in replaces it in the slot (full stays 1, no overflow);
  - pending empty: data_in launches directly.
- data_out changes only at launch edges, never while req_out=1.
- done and overflow are registered single-cycle pulses.

Decomposition:
- Shared package hs_pkg: state enum typedef (IDLE, REQ, RETURN) and default WIDTH constant.
- One sub-module: sync2 (1-bit two-flop synchronizer with synchronous Reset), instantiated for ack_in.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles -> req_out=0, data_out=0, busy=0, full=0, done=0, overflow=0.
- Single transfer: send=1 with data_in=8'hA5; bench responder raises ack_in 3 cycles after req_out rises and lowers it 3 cycles after req_out falls -> req_out=1 one cycle after send, data_out=A5 throughout, req_out falls 3 cycles after ack_in rises (2 sync + 1), one done pulse, busy=0 after.
- Pending back-to-back: send A5, then send 3C while REQ -> full=1; after A5's done, req_out re-rises on the next edge with data_out=3C, full=0; two done pulses total.
- Overflow: send 11, 22, 33 on consecutive cycles -> 11 transfers, 22 pending, 33 dropped with exactly one overflow pulse; only 11 and 22 ever appear on data_out.
- Simultaneous completion and send: pending=22 and send=44 in the done cycle -> 22 launches, 44 occupies pending, full stays 1, no overflow.
- Reset mid-transfer and stuck ack: Reset during REQ -> next edge req_out=0, full=0. Then hold ack_in=1 and send 55 -> no req_out while ack_s=1; 55 waits in pending; req_out rises 3 cycles after ack_in falls.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared types for the four-phase handshake sender.
// Holds the FSM state encoding and the default data width.
package hs_pkg;

  localparam int unsigned HS_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RETURN = 2'd2
  } hs_state_e;

endpackage

// File: rtl/sync2.sv
// sync2: 1-bit two-flop synchronizer with synchronous reset.
// Ports: Clock, Reset (sync, active-high), i_d async in, o_q synced out.
module sync2 (
  input  logic Clock,
  input  logic Reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/handshake_sender.sv
// handshake_sender: four-phase req/ack initiator with a one-word pending slot.
// Ports: Clock, Reset (sync, active-high), send/data_in in, ack_in async in,
//        req_out/data_out registered, busy, full, done/overflow pulses.
module handshake_sender
  import hs_pkg::*;
#(
  parameter int unsigned WIDTH = HS_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             send,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ack_in,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             full,
  output logic             done,
  output logic             overflow
);

  hs_state_e        r_state;
  hs_state_e        w_state_nx;
  logic             r_req;
  logic             w_req_nx;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nx;
  logic             r_pend_v;
  logic             w_pend_v_nx;
  logic [WIDTH-1:0] r_pend_d;
  logic [WIDTH-1:0] w_pend_d_nx;
  logic             r_done;
  logic             w_done_nx;
  logic             r_ovf;
  logic             w_ovf_nx;

  logic             w_ack_s;
  logic             w_launch;
  logic [WIDTH-1:0] w_launch_d;
  logic             w_stash;

  sync2 u_ack_sync (
    .Clock (Clock),
    .Reset (Reset),
    .i_d   (ack_in),
    .o_q   (w_ack_s)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_req    <= 1'b0;
      r_data   <= '0;
      r_pend_v <= 1'b0;
      r_pend_d <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_req    <= w_req_nx;
      r_data   <= w_data_nx;
      r_pend_v <= w_pend_v_nx;
      r_pend_d <= w_pend_d_nx;
      r_done   <= w_done_nx;
      r_ovf    <= w_ovf_nx;
    end
  end

  // w_launch starts a new word this edge; w_stash asks to park data_in
  // in the pending slot, which overflows if the slot stays occupied.
  always_comb begin
    w_state_nx  = r_state;
    w_req_nx    = r_req;
    w_data_nx   = r_data;
    w_pend_v_nx = r_pend_v;
    w_pend_d_nx = r_pend_d;
    w_done_nx   = 1'b0;
    w_ovf_nx    = 1'b0;
    w_launch    = 1'b0;
    w_launch_d  = data_in;
    w_stash     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_ack_s) begin
          // responder still high from before: hold the word back
          w_stash = send;
        end else if (r_pend_v) begin
          w_launch    = 1'b1;
          w_launch_d  = r_pend_d;
          w_pend_v_nx = 1'b0;
          w_stash     = send;
        end else begin
          w_launch = send;
        end
      end
      REQ: begin
        w_stash = send;
        if (w_ack_s) begin
          w_req_nx   = 1'b0;
          w_state_nx = RETURN;
        end
      end
      RETURN: begin
        if (w_ack_s) begin
          w_stash = send;
        end else begin
          w_done_nx = 1'b1;
          if (r_pend_v) begin
            w_launch    = 1'b1;
            w_launch_d  = r_pend_d;
            w_pend_v_nx = 1'b0;
            w_stash     = send;
          end else if (send) begin
            w_launch = 1'b1;
          end else begin
            w_state_nx = IDLE;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_req_nx   = 1'b0;
      end
    endcase

    if (w_launch) begin
      w_state_nx = REQ;
      w_req_nx   = 1'b1;
      w_data_nx  = w_launch_d;
    end

    if (w_stash) begin
      if (w_pend_v_nx) begin
        w_ovf_nx = 1'b1;
      end else begin
        w_pend_v_nx = 1'b1;
        w_pend_d_nx = data_in;
      end
    end
  end

  assign req_out  = r_req;
  assign data_out = r_data;
  assign busy     = (r_state != IDLE);
  assign full     = r_pend_v;
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_handshake_sender.sv
// Bench for handshake_sender: randomized sends against a queue model,
// scoreboard checked by an independent negedge monitor.
module tb_handshake_sender;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         send;
  logic [W-1:0] data_in;
  logic         ack_in;
  logic         req_out;
  logic [W-1:0] data_out;
  logic         busy;
  logic         full;
  logic         done;
  logic         overflow;

  handshake_sender #(.WIDTH(W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .send     (send),
    .data_in  (data_in),
    .ack_in   (ack_in),
    .req_out  (req_out),
    .data_out (data_out),
    .busy     (busy),
    .full     (full),
    .done     (done),
    .overflow (overflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int unsigned  edge_no;
    logic         req;
    logic [W-1:0] data;
    logic         busy;
    logic         full;
    logic         done;
    logic         ovf;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_edge = 0;
  int          n_chk  = 0;
  int          n_pass = 0;

  always @(posedge Clock) n_edge++;

  // Reference model: words accepted but not yet completed, oldest first.
  logic [W-1:0] mq[$];
  bit           m_infl;
  bit           m_req;
  bit           m_s1;
  bit           m_s2;
  logic [W-1:0] m_data;

  bit auto_ack;
  bit man_ack;
  bit rnd;
  int cnt;
  int rdly;
  int fdly;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s edge %0d: got %0h expected %0h",
                  nm, n_edge, act, exp);
  endtask

  function automatic bit will_complete();
    return m_infl && !m_req && !m_s2;
  endfunction

  task automatic m_launch();
    m_infl = 1'b1;
    m_req  = 1'b1;
    m_data = mq[0];
  endtask

  task automatic model_step(input bit rst, input bit s,
                            input logic [W-1:0] d, input bit a,
                            output exp_t e);
    bit acks;
    int pend;
    e.done = 1'b0;
    e.ovf  = 1'b0;
    if (rst) begin
      mq.delete();
      m_infl = 1'b0;
      m_req  = 1'b0;
      m_data = '0;
      m_s1   = 1'b0;
      m_s2   = 1'b0;
    end else begin
      acks = m_s2;
      m_s2 = m_s1;
      m_s1 = a;
      if (m_infl && !m_req && !acks) begin
        e.done = 1'b1;
        void'(mq.pop_front());
        m_infl = 1'b0;
      end else if (m_infl && m_req && acks) begin
        m_req = 1'b0;
      end
      if (!m_infl && !acks && mq.size() > 0) m_launch();
      if (s) begin
        pend = mq.size() - int'(m_infl);
        if (pend == 0) mq.push_back(d);
        else e.ovf = 1'b1;
      end
      if (!m_infl && !acks && mq.size() > 0) m_launch();
    end
    pend   = mq.size() - int'(m_infl);
    e.req  = m_req;
    e.data = m_data;
    e.busy = m_infl;
    e.full = (pend != 0);
  endtask

  task automatic respond();
    if (req_out && !ack_in) begin
      cnt++;
      if (cnt >= rdly) begin
        ack_in = 1'b1;
        cnt    = 0;
        if (rnd) rdly = $urandom_range(1, 5);
      end
    end else if (!req_out && ack_in) begin
      cnt++;
      if (cnt >= fdly) begin
        ack_in = 1'b0;
        cnt    = 0;
        if (rnd) fdly = $urandom_range(1, 5);
      end
    end else begin
      cnt = 0;
    end
  endtask

  task automatic step(input bit rst, input bit s, input logic [W-1:0] d);
    exp_t e;
    @(negedge Clock);
    if (auto_ack) respond();
    else ack_in = man_ack;
    Reset   = rst;
    send    = s;
    data_in = d;
    model_step(rst, s, d, ack_in, e);
    e.edge_no = n_edge + 1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  task automatic drain();
    int k = 0;
    while ((mq.size() > 0 || m_infl || ack_in) && k < 200) begin
      step(1'b0, 1'b0, '0);
      k++;
    end
    chk("drain_done", 32'(k < 200), 32'd1);
  endtask

  exp_t me;
  always @(negedge Clock) begin
    while (exp_q.size() > 0 && exp_q[0].edge_no < n_edge)
      void'(exp_q.pop_front());
    if (exp_q.size() > 0 && exp_q[0].edge_no == n_edge) begin
      me = exp_q.pop_front();
      chk("req_out",  32'(req_out),  32'(me.req));
      chk("data_out", 32'(data_out), 32'(me.data));
      chk("busy",     32'(busy),     32'(me.busy));
      chk("full",     32'(full),     32'(me.full));
      chk("done",     32'(done),     32'(me.done));
      chk("overflow", 32'(overflow), 32'(me.ovf));
    end
  end

  logic [W-1:0] rd;

  initial begin
    Reset    = 1'b1;
    send     = 1'b0;
    data_in  = '0;
    ack_in   = 1'b0;
    auto_ack = 1'b1;
    man_ack  = 1'b0;
    rnd      = 1'b0;
    cnt      = 0;
    rdly     = 3;
    fdly     = 3;

    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    idle(3);

    step(1'b0, 1'b1, 8'hA5);
    drain();

    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 8'h3C);
    drain();

    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'h33);
    drain();

    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 8'h22);
    for (int i = 0; i < 50 && !will_complete(); i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 8'h44);
    drain();

    step(1'b0, 1'b1, 8'h66);
    step(1'b0, 1'b1, 8'h77);
    step(1'b0, 1'b0, '0);
    auto_ack = 1'b0;
    man_ack  = 1'b1;
    step(1'b1, 1'b0, '0);
    idle(4);
    step(1'b0, 1'b1, 8'h55);
    step(1'b0, 1'b1, 8'h56);
    idle(4);
    man_ack = 1'b0;
    idle(5);
    cnt      = 0;
    auto_ack = 1'b1;
    drain();

    rnd = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rd = W'($urandom);
        step(1'b0, 1'b1, rd);
      end else begin
        step(1'b0, 1'b0, '0);
      end
    end
    drain();
    idle(2);
    @(negedge Clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
